// File: rtl/hs_ram_arbiter_if.sv
// Hiscore-side handshake bus of hs_ram_arbiter.
// The hiscore engine drives the master side and the arbiter takes the slave side.
interface hs_ram_arbiter_if #(
  parameter int ADDR_W = 16
);
  logic              hs_access_read;
  logic              hs_access_write;
  logic [ADDR_W-1:0] hs_address;
  logic [7:0]        hs_data_in;
  logic              hs_write;
  logic [7:0]        hs_data_out;
  logic              hs_grant;

  modport master (
    output hs_access_read, hs_access_write, hs_address, hs_data_in, hs_write,
    input  hs_data_out, hs_grant
  );

  modport slave (
    input  hs_access_read, hs_access_write, hs_address, hs_data_in, hs_write,
    output hs_data_out, hs_grant
  );
endinterface

// File: rtl/hs_ram_arbiter.sv
// Hands the CPU work-RAM port to the hiscore engine while the CPU is paused.
// Define HS_RAM_ARBITER_TIMEOUT_EN to abort pause waits after TIMEOUT cycles.
module hs_ram_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk_sys,
  input  logic              reset,
  hs_ram_arbiter_if.slave   hs,
  output logic              pause_req,
  input  logic              cpu_paused,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_dout,
  output logic              timeout
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("hs_ram_arbiter: SETTLE out of range 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("hs_ram_arbiter: TIMEOUT out of range 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PAUSE, S_SETTLE, S_GRANT, S_RELEASE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       intent;
  logic       start_ok;
  logic       tmo_hit;

  assign intent = hs.hs_access_read | hs.hs_access_write;

`ifdef HS_RAM_ARBITER_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT);

  logic [TCNT_W-1:0] tmo_cnt;
  logic              rearm_blk;

  assign tmo_hit  = (state == S_WAIT_PAUSE) && intent && !cpu_paused &&
                    (tmo_cnt == TCNT_W'(TIMEOUT - 1));
  assign start_ok = !rearm_blk;
  assign timeout  = tmo_hit;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tmo_cnt   <= '0;
      rearm_blk <= 1'b0;
    end else begin
      if (state == S_WAIT_PAUSE && !cpu_paused) tmo_cnt <= tmo_cnt + 1'b1;
      else                                      tmo_cnt <= '0;
      // after an abort, the hiscore must drop its intents once before retrying
      if (tmo_hit)      rearm_blk <= 1'b1;
      else if (!intent) rearm_blk <= 1'b0;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign start_ok = 1'b1;
  assign timeout  = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (intent && start_ok) state_nxt = S_WAIT_PAUSE;
      S_WAIT_PAUSE: begin
        if (!intent)        state_nxt = S_RELEASE;
        else if (cpu_paused) state_nxt = S_SETTLE;
        else if (tmo_hit)    state_nxt = S_RELEASE;
      end
      S_SETTLE: begin
        if (!intent)              state_nxt = S_RELEASE;
        else if (!cpu_paused)     state_nxt = S_WAIT_PAUSE;
        else if (settle_cnt == 0) state_nxt = S_GRANT;
      end
      S_GRANT:      if (!intent) state_nxt = S_RELEASE;
      S_RELEASE:    state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // held at SETTLE while waiting so the count starts fresh on every pause edge
  always_ff @(posedge clk_sys) begin
    if (reset)                                      settle_cnt <= '0;
    else if (state == S_WAIT_PAUSE)                 settle_cnt <= 4'(SETTLE);
    else if (state == S_SETTLE && settle_cnt != 0)  settle_cnt <= settle_cnt - 1'b1;
    else                                            settle_cnt <= '0;
  end

  always_comb begin
    hs.hs_grant = (state == S_GRANT);
    pause_req   = (state != S_IDLE);
    if (state == S_GRANT) begin
      ram_addr = hs.hs_address;
      ram_din  = hs.hs_data_in;
      ram_we   = hs.hs_write;
    end else begin
      ram_addr = cpu_addr;
      ram_din  = cpu_data;
      ram_we   = cpu_we;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)                 hs.hs_data_out <= 8'h00;
    else if (state == S_GRANT) hs.hs_data_out <= ram_dout;
  end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: mux vector table plus multi-cycle handshake sequences.
module tb_hs_ram_arbiter;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic        pause_req, cpu_paused, cpu_we, ram_we, timeout;
  logic [15:0] cpu_addr, ram_addr;
  logic [7:0]  cpu_data, ram_din, ram_dout;
  logic [7:0]  mem [256];

  int checks = 0;
  int errors = 0;

  hs_ram_arbiter_if #(.ADDR_W(16)) hs_bus ();

  hs_ram_arbiter #(.ADDR_W(16), .SETTLE(2), .TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset(reset), .hs(hs_bus),
    .pause_req(pause_req), .cpu_paused(cpu_paused),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_we(cpu_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .timeout(timeout)
  );

  always #5 clk_sys = ~clk_sys;

  // synchronous RAM, one-cycle read latency, low address byte only
  always @(posedge clk_sys) begin
    if (reset) begin
      mem[8'h10] <= 8'hA5;
      mem[8'h40] <= 8'h3C;
    end else if (ram_we) begin
      mem[ram_addr[7:0]] <= ram_din;
    end
    ram_dout <= mem[ram_addr[7:0]];
  end

  typedef struct {
    bit          grant;
    logic [15:0] hs_a;
    logic [7:0]  hs_d;
    logic        hs_w;
    logic [15:0] c_a;
    logic [7:0]  c_d;
    logic        c_w;
    logic [15:0] e_a;
    logic [7:0]  e_d;
    logic        e_w;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_sys);
  endtask

  task automatic apply_vec(input int i);
    nxt();
    hs_bus.hs_address = vt[i].hs_a;
    hs_bus.hs_data_in = vt[i].hs_d;
    hs_bus.hs_write   = vt[i].hs_w;
    cpu_addr = vt[i].c_a;
    cpu_data = vt[i].c_d;
    cpu_we   = vt[i].c_w;
    smp();
    chk($sformatf("vec%0d_grant", i), 32'(hs_bus.hs_grant), 32'(vt[i].grant));
    chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vt[i].e_a));
    chk($sformatf("vec%0d_din", i), 32'(ram_din), 32'(vt[i].e_d));
    chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vt[i].e_w));
  endtask

  task automatic idle_inputs();
    hs_bus.hs_access_read  = 1'b0;
    hs_bus.hs_access_write = 1'b0;
    hs_bus.hs_write        = 1'b0;
    cpu_paused = 1'b0;
    cpu_we     = 1'b0;
  endtask

  initial begin
    vt[0] = '{0, 16'h8020, 8'h5A, 1'b1, 16'h1234, 8'h11, 1'b0, 16'h1234, 8'h11, 1'b0};
    vt[1] = '{0, 16'h8021, 8'h33, 1'b1, 16'h0456, 8'h22, 1'b1, 16'h0456, 8'h22, 1'b1};
    vt[2] = '{0, 16'h0000, 8'hFF, 1'b0, 16'hFFFF, 8'hEE, 1'b1, 16'hFFFF, 8'hEE, 1'b1};
    vt[3] = '{1, 16'h8020, 8'h5A, 1'b1, 16'h1234, 8'h11, 1'b1, 16'h8020, 8'h5A, 1'b1};
    vt[4] = '{1, 16'h8030, 8'h3C, 1'b0, 16'h1111, 8'h22, 1'b1, 16'h8030, 8'h3C, 1'b0};
    vt[5] = '{1, 16'hFFFF, 8'h00, 1'b1, 16'h0000, 8'h99, 1'b0, 16'hFFFF, 8'h00, 1'b1};

    reset = 1'b1;
    idle_inputs();
    hs_bus.hs_address = 16'h0000;
    hs_bus.hs_data_in = 8'h00;
    cpu_addr = 16'h0ABC;
    cpu_data = 8'h00;
    repeat (3) nxt();
    reset = 1'b0;
    smp();
    chk("rst_grant", 32'(hs_bus.hs_grant), 32'd0);
    chk("rst_pause", 32'(pause_req), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_dout", 32'(hs_bus.hs_data_out), 32'h00);
    chk("rst_addr", 32'(ram_addr), 32'h0ABC);

    for (int i = 0; i < 3; i++) apply_vec(i);

    // read: intent at cycle 0, paused at cycle 3, grant at cycle 7
    for (int k = 0; k < 10; k++) begin
      nxt();
      cpu_we = 1'b0;
      hs_bus.hs_write = 1'b0;
      hs_bus.hs_access_read = 1'b1;
      hs_bus.hs_address = 16'h8010;
      if (k == 3) cpu_paused = 1'b1;
      smp();
      chk($sformatf("rd_grant_c%0d", k), 32'(hs_bus.hs_grant), 32'(k >= 7));
      chk($sformatf("rd_pause_c%0d", k), 32'(pause_req), 32'(k >= 1));
      if (k == 7) chk("rd_addr_c7", 32'(ram_addr), 32'h8010);
      if (k == 9) chk("rd_dout_c9", 32'(hs_bus.hs_data_out), 32'hA5);
    end
    // address change inside GRANT: two-cycle latency
    nxt(); hs_bus.hs_address = 16'h8040; smp();
    chk("lat_c0", 32'(hs_bus.hs_data_out), 32'hA5);
    nxt(); smp();
    chk("lat_c1", 32'(hs_bus.hs_data_out), 32'hA5);
    nxt(); smp();
    chk("lat_c2", 32'(hs_bus.hs_data_out), 32'h3C);

    for (int i = 3; i < 6; i++) apply_vec(i);

    // release, intent reasserted during RELEASE, then drop in WAIT_PAUSE
    for (int k = 0; k < 7; k++) begin
      nxt();
      hs_bus.hs_write = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = 16'h0321;
      cpu_paused = 1'b0;
      hs_bus.hs_access_read = (k >= 1 && k <= 3);
      smp();
      chk($sformatf("rel_grant_k%0d", k), 32'(hs_bus.hs_grant), 32'(k == 0));
      chk($sformatf("rel_pause_k%0d", k), 32'(pause_req), 32'(k != 2 && k != 6));
      if (k == 1) chk("rel_addr_k1", 32'(ram_addr), 32'h0321);
    end

    // paused glitch during SETTLE restarts the wait
    for (int k = 0; k < 11; k++) begin
      nxt();
      hs_bus.hs_access_write = 1'b1;
      cpu_paused = (k == 1 || k == 2 || k >= 5);
      smp();
      chk($sformatf("gl_grant_k%0d", k), 32'(hs_bus.hs_grant), 32'(k >= 9));
    end

    // reset while in GRANT returns the mux to the CPU
    nxt();
    cpu_addr = 16'h0777;
    hs_bus.hs_address = 16'h8050;
    smp();
    chk("rg_pre_addr", 32'(ram_addr), 32'h8050);
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b0;
    smp();
    chk("rg_grant", 32'(hs_bus.hs_grant), 32'd0);
    chk("rg_pause", 32'(pause_req), 32'd0);
    chk("rg_timeout", 32'(timeout), 32'd0);
    chk("rg_dout", 32'(hs_bus.hs_data_out), 32'h00);
    chk("rg_addr", 32'(ram_addr), 32'h0777);
    idle_inputs();
    repeat (4) nxt();

`ifdef HS_RAM_ARBITER_TIMEOUT_EN
    // pause never acknowledged: abort on WAIT_PAUSE cycle 16, blocked until intent drops
    for (int k = 0; k < 23; k++) begin
      nxt();
      cpu_paused = 1'b0;
      hs_bus.hs_access_read = (k != 20);
      smp();
      chk($sformatf("to_pulse_k%0d", k), 32'(timeout), 32'(k == 16));
      chk($sformatf("to_grant_k%0d", k), 32'(hs_bus.hs_grant), 32'd0);
      chk($sformatf("to_pause_k%0d", k), 32'(pause_req), 32'((k >= 1 && k <= 17) || k == 22));
    end
`else
    // without the abort feature the wait is unbounded
    for (int k = 0; k < 40; k++) begin
      nxt();
      cpu_paused = 1'b0;
      hs_bus.hs_access_read = 1'b1;
      smp();
      chk($sformatf("nt_timeout_k%0d", k), 32'(timeout), 32'd0);
      chk($sformatf("nt_pause_k%0d", k), 32'(pause_req), 32'(k >= 1));
      chk($sformatf("nt_grant_k%0d", k), 32'(hs_bus.hs_grant), 32'd0);
    end
`endif
    idle_inputs();
    repeat (3) nxt();
    smp();
    chk("end_pause", 32'(pause_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning RAM address width.
REQ-002 The block SHALL have parameter SETTLE, default 2, meaning cycles waited after cpu_paused before grant (range 1..15).
REQ-003 The block SHALL have parameter TIMEOUT, default 4096, meaning max cycles waited for cpu_paused (range 2..65535).
REQ-004 clk_sys  in  1  system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hs_access_read  in  1  hiscore intent to read RAM; level, held until released.
REQ-007 hs_access_write  in  1  hiscore intent to write RAM; level, held until released.
REQ-008 hs_address  in  ADDR_W  hiscore RAM address.
REQ-009 hs_data_in  in  8  hiscore write data.
REQ-010 hs_write  in  1  hiscore write strobe, one cycle per byte.
REQ-011 hs_data_out  out  8  registered read data to hiscore.
REQ-012 hs_grant  out  1  hiscore owns RAM port.
REQ-013 pause_req  out  1  request to pause CPU.
REQ-014 cpu_paused  in  1  CPU halted acknowledge.
REQ-015 cpu_addr  in  ADDR_W  CPU RAM address.
REQ-016 cpu_data  in  8  CPU write data.
REQ-017 cpu_we  in  1  CPU write enable.
REQ-018 ram_addr  out  ADDR_W  muxed RAM address.
REQ-019 ram_din  out  8  muxed RAM write data.
REQ-020 ram_we  out  1  muxed RAM write enable.
REQ-021 ram_dout  in  8  RAM read data, valid one cycle after address.
REQ-022 timeout  out  1  one-cycle pulse on pause-wait abort.

Function
REQ-023 FSM states SHALL be IDLE, WAIT_PAUSE, SETTLE, GRANT, RELEASE.
REQ-024 IDLE -> WAIT_PAUSE when (hs_access_read | hs_access_write); pause_req asserted from the cycle after entry through RELEASE inclusive.
REQ-025 WAIT_PAUSE -> SETTLE on first cycle cpu_paused=1; settle counter loaded with SETTLE.
REQ-026 SETTLE SHALL count down SETTLE cycles, then enter GRANT; cpu_paused dropping during SETTLE returns FSM to WAIT_PAUSE.
REQ-027 GRANT: hs_grant=1; ram_addr=hs_address, ram_din=hs_data_in, ram_we=hs_write, combinationally.
REQ-028 Outside GRANT: ram_addr=cpu_addr, ram_din=cpu_data, ram_we=cpu_we; hiscore write strobes SHALL be ignored.
REQ-029 hs_data_out SHALL register ram_dout every GRANT cycle; read latency 2 cycles from hs_address change to hs_data_out.
REQ-030 GRANT -> RELEASE when both intents low; RELEASE lasts one cycle with hs_grant=0, pause_req=1, then IDLE with pause_req=0.
REQ-031 Intent reasserted during RELEASE SHALL be ignored; re-arbitration starts from IDLE next cycle.
REQ-032 cpu_we during GRANT SHALL be discarded (CPU paused by contract).
REQ-033 Intents dropped in WAIT_PAUSE or SETTLE SHALL go to RELEASE without granting.

Reset
REQ-034 On reset: state=IDLE, hs_grant=0, pause_req=0, timeout=0, hs_data_out=8'h00, counters=0.
REQ-035 Reset mid-GRANT SHALL return the RAM mux to CPU the cycle after reset is sampled.

Configuration
REQ-036 Macro HS_RAM_ARBITER_TIMEOUT_EN defined: WAIT_PAUSE counts cycles; at TIMEOUT cycles without cpu_paused, pulse timeout one cycle and go to RELEASE; new attempt only after intents drop low for one cycle.
REQ-037 Macro not defined: WAIT_PAUSE waits indefinitely; timeout tied 0; no timeout counter synthesized.

Verification
REQ-038 Read: hs_access_read=1, cpu_paused at cycle 3 -> hs_grant at cycle 3+1+SETTLE(=2)+1; hs_address=16'h8010, ram_dout=8'hA5 -> hs_data_out=8'hA5 two cycles later.
REQ-039 Write: in GRANT, hs_write pulse with hs_address=16'h8020, hs_data_in=8'h5A -> ram_we=1, ram_addr=16'h8020, ram_din=8'h5A same cycle; cpu_we=1 concurrently not visible.
REQ-040 Release: drop intents in GRANT -> hs_grant=0 next cycle, pause_req=0 one cycle later, ram_addr follows cpu_addr.
REQ-041 Timeout (macro on, TIMEOUT=16): cpu_paused held 0 -> timeout pulse at cycle 16 of WAIT_PAUSE, hs_grant never 1, pause_req low after RELEASE.
REQ-042 Glitch: cpu_paused drops during SETTLE -> FSM back to WAIT_PAUSE, no grant until paused stable for SETTLE cycles.
REQ-043 Reset in GRANT -> all outputs at reset values, ram mux on CPU next cycle.
